inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 108 ++++++++++
 tb/tb_inst_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch sequencer with prefetch FIFO (optional bypass: FETCHQ_BYPASS_EN)
module inst_fetch_queue #(
  parameter int                    DEPTH      = 4,
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [WORD_WIDTH-1:0]        inst_addr,
  input  logic [WORD_WIDTH-1:0]        inst,
  input  logic                         redirect,
  input  logic [WORD_WIDTH-1:0]        redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_WIDTH-1:0]        out_inst,
  output logic [WORD_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_WIDTH-1:0] fpc_q, fpc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WORD_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [WORD_WIDTH-1:0] inst_mem_q [DEPTH];

  logic head_valid;
  logic bypass;
  logic take_bypass;
  logic pop;
  logic fetch_adv;
  logic fifo_push;

  assign inst_addr = fpc_q;
  assign occupancy = count_q;

  // Output selection, handshake decode and next-state computation
  always_comb begin
    head_valid = (count_q != '0) & ~redirect;
`ifdef FETCHQ_BYPASS_EN
    // An empty queue forwards the word being fetched this cycle straight to decode.
    bypass = (count_q == '0) & ~redirect & ~rst;
`else
    bypass = 1'b0;
`endif
    out_valid = head_valid | bypass;
    out_inst  = '0;
    out_pc    = '0;
    if (bypass) begin
      out_inst = inst;
      out_pc   = fpc_q;
    end else if (head_valid) begin
      out_inst = inst_mem_q[rd_ptr_q];
      out_pc   = pc_mem_q[rd_ptr_q];
    end

    pop         = head_valid & out_ready;
    take_bypass = bypass & out_ready;
    // The fetch PC advances whenever the fetched word is accepted somewhere:
    // into the FIFO, or directly by decode through the bypass.
    fetch_adv   = ~redirect & ((count_q < CNT_W'(DEPTH)) | pop);
    fifo_push   = fetch_adv & ~take_bypass;

    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      fpc_d    = {redirect_pc[WORD_WIDTH-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch_adv) fpc_d = fpc_q + WORD_WIDTH'(4);
      if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (fifo_push & ~pop)      count_d = count_q + CNT_W'(1);
      else if (pop & ~fifo_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state: fetch PC, pointers and entry count
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && fifo_push) begin
      pc_mem_q[wr_ptr_q]   <= fpc_q;
      inst_mem_q[wr_ptr_q] <= inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FETCHQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  inst_fetch_queue #(.DEPTH(4), .WORD_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst(inst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Byte-addressed memory with a distinct pattern per byte, read big-endian.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return (a[7:0] * 8'd7 + 8'd3) ^ a[15:8] ^ a[31:24];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
  endfunction

  always_comb inst = mem_word(inst_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", out_inst); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", out_pc); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", inst_addr); end
  endtask

  task automatic test_stream();
    logic        ev;
    logic [31:0] epc, ein;
    do_reset();
    step();
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c > 0) step();
      settle();
      ev  = (c >= LAT);
      epc = ev ? 32'(4 * (c - LAT)) : 32'h0;
      ein = ev ? mem_word(epc) : 32'h0;
      n_checks++; if (out_valid !== ev) begin n_fail++; $display("FAIL stream_valid c=%0d got %0b want %0b", c, out_valid, ev); end
      n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL stream_pc c=%0d got %h want %h", c, out_pc, epc); end
      n_checks++; if (out_inst !== ein) begin n_fail++; $display("FAIL stream_inst c=%0d got %h want %h", c, out_inst, ein); end
    end
  endtask

  task automatic test_stall_drain();
    logic [31:0] epc;
    do_reset();
    step();
    rst = 1'b0; out_ready = 1'b0;
    repeat (10) step();
    settle();
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL stall_occ got %0d want 4", occupancy); end
    n_checks++; if (inst_addr !== 32'h10) begin n_fail++; $display("FAIL stall_addr got %h want 10", inst_addr); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %0b want 1", out_valid); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      settle();
      epc = 32'(4 * k);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid k=%0d got %0b want 1", k, out_valid); end
      n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL drain_pc k=%0d got %h want %h", k, out_pc, epc); end
      n_checks++; if (out_inst !== mem_word(epc)) begin n_fail++; $display("FAIL drain_inst k=%0d got %h want %h", k, out_inst, mem_word(epc)); end
      n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL drain_occ k=%0d got %0d want 4", k, occupancy); end
      n_checks++; if (inst_addr !== 32'h10 + epc) begin n_fail++; $display("FAIL drain_addr k=%0d got %h want %h", k, inst_addr, 32'h10 + epc); end
    end
  endtask

  task automatic test_redirect();
    logic        ev;
    logic [31:0] epc;
    do_reset();
    step();
    rst = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    settle();
    n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL redir_pre_occ got %0d want 3", occupancy); end
    redirect = 1'b1; redirect_pc = 32'h103; out_ready = 1'b1;
    settle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %0b want 0", out_valid); end
    step();
    redirect = 1'b0;
    for (int c = 0; c <= LAT + 1; c++) begin
      if (c > 0) step();
      settle();
      if (c == 0) begin
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL redir_occ got %0d want 0", occupancy); end
        n_checks++; if (inst_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %h want 100", inst_addr); end
      end
      ev  = (c >= LAT);
      epc = ev ? 32'h100 + 32'(4 * (c - LAT)) : 32'h0;
      n_checks++; if (out_valid !== ev) begin n_fail++; $display("FAIL redir_out_valid c=%0d got %0b want %0b", c, out_valid, ev); end
      n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL redir_out_pc c=%0d got %h want %h", c, out_pc, epc); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    rst = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    settle();
    n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL rmid_pre_occ got %0d want 2", occupancy); end
    rst = 1'b1;
    step();
    settle();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %0b want 0", out_valid); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rmid_inst got %h want 0", out_inst); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_pc got %h want 0", out_pc); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rmid_occ got %0d want 0", occupancy); end
    n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_addr got %h want 0", inst_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] epc;
    do_reset();
    step();
    rst = 1'b0; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    settle();
    n_checks++; if (inst_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got %h want fffffffc", inst_addr); end
    step();
    settle();
    n_checks++; if (inst_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got %h want 0", inst_addr); end
    epc = (LAT == 1) ? 32'hFFFF_FFFC : 32'h0;
    n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL wrap_pc1 got %h want %h", out_pc, epc); end
    n_checks++; if (out_inst !== mem_word(epc)) begin n_fail++; $display("FAIL wrap_inst1 got %h want %h", out_inst, mem_word(epc)); end
    step();
    settle();
    epc = (LAT == 1) ? 32'h0 : 32'h4;
    n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL wrap_pc2 got %h want %h", out_pc, epc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall_drain();
    test_redirect();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
